bnn_param_loader: RTL and testbench

BNN_PARAM_LOADER -- requirements
Module: bnn_param_loader

---
 rtl/bnn_param_loader.sv | 118 +++++++++++
 tb/tb_bnn_param_loader.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bnn_param_loader.sv
// bnn_param_loader: receives one layer's packed parameter image as a stream
// of WORD_W-bit words, assembles it in a shadow register and commits it to
// params_o atomically once a correctly framed session completes. Framing
// errors (early or missing last) abort the session without touching the
// committed image.
module bnn_param_loader #(
    parameter int PARAM_BITS = 240,
    parameter int WORD_W     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [WORD_W-1:0]     data_i,
    input  logic                  valid_i,
    input  logic                  last_i,
    output logic                  ready_o,
    output logic [PARAM_BITS-1:0] params_o,
    output logic                  params_valid_o,
    output logic                  busy_o,
    output logic                  error_o
);

    localparam int N_WORDS = (PARAM_BITS + WORD_W - 1) / WORD_W;
    localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    // Shadow holds whole words; bits at or above PARAM_BITS are never committed.
    localparam int SH_W    = N_WORDS * WORD_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SH_W-1:0]         shadow_q, shadow_d;
    logic [PARAM_BITS-1:0]   params_q, params_d;
    logic                    pvalid_q, pvalid_d;
    logic                    wr_en;
    logic                    commit;

    // Next-state logic: session framing, counter advance and commit decision.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE, ERR: begin
                if (start_i) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (start_i) begin
                    // Restart wins over any same-cycle word, which is dropped.
                    cnt_d = '0;
                end else if (valid_i) begin
                    wr_en = 1'b1;
                    if (last_i) begin
                        if (cnt_q == LAST_IDX) begin
                            commit  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = ERR;
                        end
                    end else if (cnt_q == LAST_IDX) begin
                        state_d = ERR;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Shadow write path and commit image, including the word accepted this cycle.
    always_comb begin
        shadow_d = shadow_q;
        for (int k = 0; k < N_WORDS; k++) begin
            if (wr_en && (cnt_q == CNT_W'(k))) begin
                shadow_d[k*WORD_W +: WORD_W] = data_i;
            end
        end
        params_d = commit ? shadow_d[PARAM_BITS-1:0] : params_q;
        pvalid_d = commit ? 1'b1 : pvalid_q;
    end

    // State, counter, shadow and committed image registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            params_q <= '0;
            pvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            params_q <= params_d;
            pvalid_q <= pvalid_d;
        end
    end

    assign ready_o        = (state_q == LOAD);
    assign busy_o         = (state_q == LOAD);
    assign error_o        = (state_q == ERR);
    assign params_o       = params_q;
    assign params_valid_o = pvalid_q;

endmodule

// File: tb/tb_bnn_param_loader.sv
// Testbench for bnn_param_loader: directed framing scenarios followed by a
// randomized run, all checked against a transaction-level session model.
module tb_bnn_param_loader;

    localparam int PB = 240;
    localparam int WW = 32;
    localparam int NW = (PB + WW - 1) / WW;

    logic          clk = 1'b0;
    logic          rst_i, start_i, valid_i, last_i;
    logic [WW-1:0] data_i;
    logic          ready_o, params_valid_o, busy_o, error_o;
    logic [PB-1:0] params_o;

    int checks   = 0;
    int failures = 0;

    // Session model: open flag, aborted flag, words gathered, committed image.
    bit            m_open, m_err, m_pv;
    logic [WW-1:0] m_words[$];
    logic [PB-1:0] m_params;
    logic [PB-1:0] img_a;

    bnn_param_loader #(.PARAM_BITS(PB), .WORD_W(WW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .data_i(data_i),
        .valid_i(valid_i), .last_i(last_i), .ready_o(ready_o),
        .params_o(params_o), .params_valid_o(params_valid_o),
        .busy_o(busy_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [PB-1:0] obs, input logic [PB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [PB-1:0] build_image();
        logic [NW*WW-1:0] full;
        full = '0;
        foreach (m_words[i]) full[i*WW +: WW] = m_words[i];
        return full[PB-1:0];
    endfunction

    task automatic model(input logic r, input logic st, input logic v, input logic ls, input logic [WW-1:0] d);
        if (r) begin
            m_open = 0; m_err = 0; m_pv = 0; m_params = '0; m_words.delete();
        end else if (!m_open) begin
            if (st) begin
                m_open = 1; m_err = 0; m_words.delete();
            end
        end else if (st) begin
            m_words.delete();
        end else if (v) begin
            m_words.push_back(d);
            if (ls || m_words.size() == NW) begin
                m_open = 0;
                if (ls && m_words.size() == NW) begin
                    m_params = build_image();
                    m_pv = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ready"}, PB'(ready_o), PB'(m_open));
        chk({tag, ".busy"},  PB'(busy_o),  PB'(m_open));
        chk({tag, ".error"}, PB'(error_o), PB'(m_err));
        chk({tag, ".pvalid"}, PB'(params_valid_o), PB'(m_pv));
        chk({tag, ".params"}, params_o, m_params);
    endtask

    // One clock cycle: drive, clock, advance the model, compare.
    task automatic step(input logic r, input logic st, input logic v, input logic ls,
                        input logic [WW-1:0] d, input string tag);
        rst_i = r; start_i = st; valid_i = v; last_i = ls; data_i = d;
        @(posedge clk);
        #1;
        model(r, st, v, ls, d);
        check_all(tag);
    endtask

    initial begin
        logic r, st, v, ls;
        logic [WW-1:0] d;
        rst_i = 1; start_i = 0; valid_i = 0; last_i = 0; data_i = '0;
        m_open = 0; m_err = 0; m_pv = 0; m_params = '0;

        // Reset state
        step(1, 0, 0, 0, 32'h0, "reset");
        step(0, 0, 1, 1, 32'hDEAD_BEEF, "idle_ignore");

        // Nominal session
        step(0, 1, 0, 0, 32'h0, "nom_start");
        for (int i = 1; i <= NW; i++) step(0, 0, 1, (i == NW), WW'(i), "nom_word");
        chk("nom.w0", PB'(params_o[31:0]), PB'(32'h1));
        chk("nom.w6", PB'(params_o[223:192]), PB'(32'h7));
        chk("nom.top", PB'(params_o[239:224]), PB'(16'h0008));
        chk("nom.pv", PB'(params_valid_o), PB'(1'b1));
        chk("nom.busy", PB'(busy_o), PB'(1'b0));
        img_a = params_o;

        // Stall/gaps: valid low on alternate cycles
        step(0, 1, 0, 0, 32'h0, "gap_start");
        for (int i = 1; i <= NW; i++) begin
            step(0, 0, 0, 1, 32'hFFFF_FFFF, "gap_bubble");
            step(0, 0, 1, (i == NW), WW'(i), "gap_word");
        end
        chk("gap.same", params_o, img_a);

        // Early last
        step(0, 1, 0, 0, 32'h0, "early_start");
        for (int i = 1; i <= 3; i++) step(0, 0, 1, (i == 3), 32'h1111_0000 + WW'(i), "early_word");
        chk("early.err", PB'(error_o), PB'(1'b1));
        chk("early.ready", PB'(ready_o), PB'(1'b0));
        chk("early.keep", params_o, img_a);
        step(0, 1, 0, 0, 32'h0, "early_restart");
        chk("early.clr", PB'(error_o), PB'(1'b0));

        // Missing last (session already open from the restart above)
        for (int i = 1; i <= NW; i++) step(0, 0, 1, 0, 32'h2222_0000 + WW'(i), "miss_word");
        chk("miss.err", PB'(error_o), PB'(1'b1));
        step(0, 0, 1, 1, 32'h3333_3333, "miss_9th");
        chk("miss.keep", params_o, img_a);

        // Restart mid-session, same-cycle word dropped
        step(0, 1, 0, 0, 32'h0, "rs_start");
        for (int i = 1; i <= 5; i++) step(0, 0, 1, 0, 32'h4444_0000 + WW'(i), "rs_word");
        step(0, 1, 1, 0, 32'h5555_5555, "rs_restart");
        for (int i = 1; i <= NW; i++) step(0, 0, 1, (i == NW), 32'hA5A5_A5A5, "rs_a5");
        chk("rs.pattern", params_o, {(PB/8){8'hA5}});
        chk("rs.noerr", PB'(error_o), PB'(1'b0));

        // Reset mid-load
        step(0, 1, 0, 0, 32'h0, "rml_start");
        for (int i = 1; i <= 4; i++) step(0, 0, 1, 0, 32'h6666_0000 + WW'(i), "rml_word");
        step(1, 1, 1, 1, 32'h7777_7777, "rml_reset");
        chk("rml.params", params_o, '0);
        chk("rml.pv", PB'(params_valid_o), PB'(1'b0));
        step(0, 1, 0, 0, 32'h0, "rml_start2");
        for (int i = 1; i <= NW; i++) step(0, 0, 1, (i == NW), 32'h0100_0000 * WW'(i), "rml_word2");
        chk("rml.pv2", PB'(params_valid_o), PB'(1'b1));

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            st = ($urandom_range(0, 24) == 0);
            v  = ($urandom_range(0, 3) != 0);
            if (m_words.size() == NW - 1) ls = ($urandom_range(0, 9) != 0);
            else                          ls = ($urandom_range(0, 19) == 0);
            d  = $urandom;
            step(r, st, v, ls, d, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
